sr_latch_seq: RTL and testbench
===============================

SR_LATCH_SEQ -- requirements
Module: sr_latch_seq

Interface
REQ-001 The module SHALL have one parameter: PULSE_CYCLES, 2, number of cycles the latch gate is held open; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req0 / req1  input  1 each  write request from requester 0 / 1; level, held until granted.
REQ-005 data0 / data1  input  1 each  bit requester 0 / 1 wants stored (1 = set, 0 = reset).
REQ-006 gnt0 / gnt1  output  1 each  one-cycle grant; the requester's data has been captured.
REQ-007 latch_C  output  1  gate of the gated SR latch, active-high.
REQ-008 latch_S / latch_R  output  1 each  set / reset inputs of the latch, active-low (1,1 = hold).
REQ-009 latch_Q / latch_Qbar  input  1 each  latch outputs, fed back.
REQ-010 busy  output  1  high while a write sequence is in progress.
REQ-011 done  output  1  one-cycle pulse when a write sequence completes.
REQ-012 err  output  1  valid only with done; 1 = readback mismatch.

Function
REQ-013 The FSM SHALL have states IDLE, SETUP, PULSE, HOLD, VERIFY; VERIFY exists only per REQ-027.
REQ-014 In IDLE with any req high at a rising edge, the FSM SHALL capture the winner's data, go to SETUP, and assert that gnt only during the SETUP cycle.
REQ-015 Arbitration SHALL be round-robin: if both req are high, grant the requester not granted last; a single request is always granted.
REQ-016 After reset the arbiter SHALL treat requester 1 as last granted, so requester 0 wins the first tie.
REQ-017 SETUP SHALL last 1 cycle: latch_C=0, latch_S=~data, latch_R=data.
REQ-018 PULSE SHALL last exactly PULSE_CYCLES cycles with latch_C=1 and S/R unchanged from SETUP.
REQ-019 HOLD SHALL last 1 cycle: latch_C=0, S/R still driven, satisfying hold time.
REQ-020 In every state other than SETUP/PULSE/HOLD: latch_C=0, latch_S=1, latch_R=1.
REQ-021 latch_S=0 and latch_R=0 together SHALL never occur on any cycle.
REQ-022 busy SHALL be 1 in SETUP, PULSE, HOLD, VERIFY and 0 in IDLE.
REQ-023 done SHALL be a registered pulse high in the first IDLE cycle after the sequence; a new request may be accepted at that same edge.
REQ-024 Requests arriving while busy SHALL be ignored until IDLE; no queuing beyond the requester holding req.
REQ-025 Dropping req mid-sequence SHALL NOT abort the sequence.

Reset
REQ-026 With rst high at a rising edge the module SHALL enter IDLE and drive latch_C=0, latch_S=1, latch_R=1, gnt0=gnt1=0, busy=0, done=0, err=0 from the next cycle, including mid-sequence; the latch's stored value is not disturbed and no done is produced for the aborted write.

Configuration
REQ-027 Macro SR_LATCH_SEQ_READBACK_EN defined: HOLD goes to VERIFY (1 cycle, S/R released); VERIFY samples latch_Q/latch_Qbar and err = ~(Q==data && Qbar==~data), presented with done.
REQ-028 Macro undefined: HOLD goes directly to IDLE, VERIFY does not exist, err is constant 0, sequence is one cycle shorter.

Verification
REQ-029 Reset then req0=1,data0=1 at edge k, PULSE_CYCLES=2, macro defined -> gnt0 at k+1, latch_C=1 at k+2..k+3, S=0/R=1 at k+1..k+4, done=1 err=0 at k+6.
REQ-030 req0 and req1 both high continuously, data0=1, data1=0 -> grants alternate gnt0, gnt1, gnt0; latch Q toggles 1,0,1; S=R=0 never seen.
REQ-031 Latch model stuck at Q=0, write data=1, macro defined -> done=1 with err=1; same stimulus with macro undefined -> done one cycle earlier, err=0.
REQ-032 rst asserted during PULSE -> next cycle latch_C=0, S=R=1, busy=0; no done; stored latch value unchanged.
REQ-033 PULSE_CYCLES=1 and 15 -> latch_C high for exactly 1 and 15 cycles respectively.
REQ-034 req1 asserted while busy, held -> gnt1 in the SETUP cycle immediately following done, not earlier.

Source files
------------

// File: rtl/sr_latch_seq_if.sv
// Requester/latch bundle for sr_latch_seq.
// Handshake: a requester raises reqN (a level) with dataN valid and holds both
// until gntN is seen; gntN is a one-cycle pulse meaning dataN has been captured
// and reqN may be dropped. latch_* are the gated SR latch pins (S/R active-low),
// latch_Q/latch_Qbar are the latch outputs fed back. state_dbg mirrors the FSM.
interface sr_latch_seq_if;
  logic       req0;
  logic       req1;
  logic       data0;
  logic       data1;
  logic       gnt0;
  logic       gnt1;
  logic       latch_C;
  logic       latch_S;
  logic       latch_R;
  logic       latch_Q;
  logic       latch_Qbar;
  logic       busy;
  logic       done;
  logic       err;
  logic [2:0] state_dbg;

  // Environment side: requesters plus the physical latch.
  modport master (
    output req0, req1, data0, data1, latch_Q, latch_Qbar,
    input  gnt0, gnt1, latch_C, latch_S, latch_R, busy, done, err, state_dbg
  );

  // Controller side.
  modport slave (
    input  req0, req1, data0, data1, latch_Q, latch_Qbar,
    output gnt0, gnt1, latch_C, latch_S, latch_R, busy, done, err, state_dbg
  );
endinterface

// File: rtl/sr_latch_seq.sv
// sr_latch_seq: two-requester, round-robin write controller for an external
// gated SR latch (gate active-high, S/R active-low).
// Write sequence: SETUP (1) -> PULSE (PULSE_CYCLES, gate open) -> HOLD (1)
// [-> VERIFY (1)] -> IDLE with a registered done pulse.
// Optional feature: define SR_LATCH_SEQ_READBACK_EN to add the VERIFY state,
// which reads latch_Q/latch_Qbar back and reports a mismatch on err with done.
module sr_latch_seq #(
  parameter int unsigned PULSE_CYCLES = 2  // legal range 1..15
) (
  input logic           clk,
  input logic           rst,
  sr_latch_seq_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    PULSE  = 3'd2,
`ifdef SR_LATCH_SEQ_READBACK_EN
    HOLD   = 3'd3,
    VERIFY = 3'd4
`else
    HOLD   = 3'd3
`endif
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(PULSE_CYCLES - 1);

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic       data_r, data_nx;   // captured write value
  logic       last_r, last_nx;   // requester granted last (1 = requester 1)
  logic       win_r, win_nx;     // requester owning the current sequence
  logic       done_r, done_nx;
  logic       err_r, err_nx;
  logic       pick;
  logic       gnt0, gnt1, lat_c, lat_s, lat_r, busy;

  // State and datapath registers; reset leaves the latch pins idle (hold).
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      data_r <= 1'b0;
      last_r <= 1'b1;
      win_r  <= 1'b0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      data_r <= data_nx;
      last_r <= last_nx;
      win_r  <= win_nx;
      done_r <= done_nx;
      err_r  <= err_nx;
    end
  end

  // Next-state, arbitration and Moore outputs; S/R default to hold (1,1).
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    data_nx  = data_r;
    last_nx  = last_r;
    win_nx   = win_r;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    pick     = 1'b0;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    lat_c    = 1'b0;
    lat_s    = 1'b1;
    lat_r    = 1'b1;
    busy     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          // On a tie the requester not granted last wins.
          pick     = (bus.req0 && bus.req1) ? ~last_r : bus.req1;
          win_nx   = pick;
          last_nx  = pick;
          data_nx  = pick ? bus.data1 : bus.data0;
          state_nx = SETUP;
        end
      end
      SETUP: begin
        busy     = 1'b1;
        gnt0     = ~win_r;
        gnt1     = win_r;
        lat_s    = ~data_r;
        lat_r    = data_r;
        cnt_nx   = 4'd0;
        state_nx = PULSE;
      end
      PULSE: begin
        busy  = 1'b1;
        lat_c = 1'b1;
        lat_s = ~data_r;
        lat_r = data_r;
        if (cnt == CNT_LAST) begin
          state_nx = HOLD;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      HOLD: begin
        busy  = 1'b1;
        lat_s = ~data_r;
        lat_r = data_r;
`ifdef SR_LATCH_SEQ_READBACK_EN
        state_nx = VERIFY;
`else
        state_nx = IDLE;
        done_nx  = 1'b1;
`endif
      end
`ifdef SR_LATCH_SEQ_READBACK_EN
      VERIFY: begin
        busy     = 1'b1;
        state_nx = IDLE;
        done_nx  = 1'b1;
        err_nx   = ~((bus.latch_Q == data_r) && (bus.latch_Qbar == ~data_r));
      end
`endif
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

`ifndef SR_LATCH_SEQ_READBACK_EN
  // Feedback pins are only consumed by the readback state.
  logic unused_fb;
  assign unused_fb = bus.latch_Q ^ bus.latch_Qbar;
`endif

  assign bus.gnt0      = gnt0;
  assign bus.gnt1      = gnt1;
  assign bus.latch_C   = lat_c;
  assign bus.latch_S   = lat_s;
  assign bus.latch_R   = lat_r;
  assign bus.busy      = busy;
  assign bus.done      = done_r;
  assign bus.err       = err_r;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_sr_latch_seq.sv
// Bench for sr_latch_seq: cycle-by-cycle vector table on a PULSE_CYCLES=2
// instance with a behavioural gated SR latch, then hand sequences for
// round-robin, mid-sequence reset, stuck latch readback and pulse widths 1/15.
module tb_sr_latch_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sr_latch_seq_if ifc ();
  sr_latch_seq_if ifc1 ();
  sr_latch_seq_if ifc15 ();

  sr_latch_seq #(.PULSE_CYCLES(2))  dut   (.clk(clk), .rst(rst), .bus(ifc.slave));
  sr_latch_seq #(.PULSE_CYCLES(1))  dut1  (.clk(clk), .rst(rst), .bus(ifc1.slave));
  sr_latch_seq #(.PULSE_CYCLES(15)) dut15 (.clk(clk), .rst(rst), .bus(ifc15.slave));

  // Gated SR latch model (gate active-high, S/R active-low), with stuck-at-0 mode.
  logic lq = 1'b0;
  logic stuck = 1'b0;
  always @(negedge clk) begin
    if (ifc.latch_C) begin
      if (!ifc.latch_S) lq = 1'b1;
      else if (!ifc.latch_R) lq = 1'b0;
    end
  end
  assign ifc.latch_Q      = stuck ? 1'b0 : lq;
  assign ifc.latch_Qbar   = ~ifc.latch_Q;
  assign ifc1.latch_Q     = 1'b0;
  assign ifc1.latch_Qbar  = 1'b1;
  assign ifc15.latch_Q    = 1'b0;
  assign ifc15.latch_Qbar = 1'b1;

  // S and R both low is forbidden on every instance.
  int sr_viol = 0;
  always @(negedge clk) begin
    if (!rst && ((!ifc.latch_S && !ifc.latch_R) || (!ifc1.latch_S && !ifc1.latch_R) ||
                 (!ifc15.latch_S && !ifc15.latch_R)))
      sr_viol = sr_viol + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Row: inputs applied before an edge, outputs expected after it.
  // exp = {gnt0, gnt1, latch_C, latch_S, latch_R, busy, done, err}
  typedef struct {
    logic       rst;
    logic       r0;
    logic       r1;
    logic       d0;
    logic       d1;
    logic [7:0] exp;
  } vec_t;
  vec_t vq[$];

  function automatic void add(input logic r, input logic r0, input logic r1,
                              input logic d0, input logic d1, input logic [7:0] e);
    vec_t v;
    v.rst = r; v.r0 = r0; v.r1 = r1; v.d0 = d0; v.d1 = d1; v.exp = e;
    vq.push_back(v);
  endfunction

  function automatic logic [7:0] obs();
    return {ifc.gnt0, ifc.gnt1, ifc.latch_C, ifc.latch_S, ifc.latch_R,
            ifc.busy, ifc.done, ifc.err};
  endfunction

`ifdef SR_LATCH_SEQ_READBACK_EN
  localparam int DONE_LAT = 5;
  localparam logic STUCK_ERR = 1'b1;
`else
  localparam int DONE_LAT = 4;
  localparam logic STUCK_ERR = 1'b0;
`endif

  initial begin
    logic found;
    logic q_hold;
    int   lat;
    int   c1, c15, dn1, dn15;
    logic [3:0] exp_gnt1;
    logic [3:0] exp_q;

    ifc.req0 = 0; ifc.req1 = 0; ifc.data0 = 0; ifc.data1 = 0;
    ifc1.req0 = 0; ifc1.req1 = 0; ifc1.data0 = 0; ifc1.data1 = 0;
    ifc15.req0 = 0; ifc15.req1 = 0; ifc15.data0 = 0; ifc15.data1 = 0;

    // Reset, then write 1 from requester 0 (req dropped after grant).
    add(1, 0, 0, 0, 0, 8'b0001_1000);
    add(0, 1, 0, 1, 0, 8'b1000_1100);  // SETUP, gnt0, S=0 R=1
    add(0, 0, 0, 0, 0, 8'b0010_1100);  // PULSE
    add(0, 0, 0, 0, 0, 8'b0010_1100);  // PULSE
    add(0, 0, 0, 0, 0, 8'b0000_1100);  // HOLD
`ifdef SR_LATCH_SEQ_READBACK_EN
    add(0, 0, 0, 0, 0, 8'b0001_1100);  // VERIFY, S/R released
`endif
    add(0, 0, 0, 0, 0, 8'b0001_1010);  // IDLE + done
    add(0, 0, 0, 0, 0, 8'b0001_1000);  // IDLE
    // Requester 1 writes 0; requester 0 shows up while busy and must wait.
    add(0, 0, 1, 0, 0, 8'b0101_0100);  // SETUP, gnt1, S=1 R=0
    add(0, 1, 1, 1, 0, 8'b0011_0100);  // PULSE
    add(0, 1, 1, 1, 0, 8'b0011_0100);  // PULSE
    add(0, 1, 1, 1, 0, 8'b0001_0100);  // HOLD
`ifdef SR_LATCH_SEQ_READBACK_EN
    add(0, 1, 1, 1, 0, 8'b0001_1100);  // VERIFY
`endif
    add(0, 1, 1, 1, 0, 8'b0001_1010);  // IDLE + done
    add(0, 1, 1, 1, 0, 8'b1000_1100);  // tie at done edge: requester 0 wins
    add(0, 0, 0, 0, 0, 8'b0010_1100);
    add(0, 0, 0, 0, 0, 8'b0010_1100);
    add(0, 0, 0, 0, 0, 8'b0000_1100);
`ifdef SR_LATCH_SEQ_READBACK_EN
    add(0, 0, 0, 0, 0, 8'b0001_1100);
`endif
    add(0, 0, 0, 0, 0, 8'b0001_1010);
    add(0, 0, 0, 0, 0, 8'b0001_1000);

    foreach (vq[i]) begin
      rst = vq[i].rst;
      ifc.req0 = vq[i].r0; ifc.req1 = vq[i].r1;
      ifc.data0 = vq[i].d0; ifc.data1 = vq[i].d1;
      tick();
      chk($sformatf("vec%0d", i), obs(), vq[i].exp);
    end
    chk("table_latch_q", lq, 1'b1);

    // Round-robin under continuous contention: gnt0, gnt1, gnt0; Q 1, 0, 1.
    rst = 1; tick(); rst = 0;
    exp_gnt1 = 4'b0010;
    exp_q    = 4'b0101;
    ifc.req0 = 1; ifc.req1 = 1; ifc.data0 = 1; ifc.data1 = 0;
    for (int g = 0; g < 3; g++) begin
      found = 0;
      for (int k = 0; k < 12 && !found; k++) begin
        tick();
        if (ifc.gnt0 || ifc.gnt1) found = 1;
      end
      chk($sformatf("rr_gnt_seen%0d", g), found, 1'b1);
      chk($sformatf("rr_gnt1_%0d", g), ifc.gnt1, exp_gnt1[g]);
      if (g == 2) begin ifc.req0 = 0; ifc.req1 = 0; end
      found = 0;
      for (int k = 0; k < 12 && !found; k++) begin
        tick();
        if (ifc.done) found = 1;
      end
      chk($sformatf("rr_done%0d", g), found, 1'b1);
      chk($sformatf("rr_q%0d", g), lq, exp_q[g]);
    end
    tick();

    // Reset during PULSE: pins go idle next cycle, no done, latch left alone.
    ifc.req1 = 1; ifc.data1 = ~lq;
    tick();
    chk("mid_rst_setup", ifc.gnt1, 1'b1);
    ifc.req1 = 0;
    tick();
    chk("mid_rst_pulse", ifc.latch_C, 1'b1);
    rst = 1;
    tick();
    rst = 0;
    chk("mid_rst_pins", {ifc.latch_C, ifc.latch_S, ifc.latch_R, ifc.busy, ifc.gnt1}, 5'b01100);
    q_hold = lq;
    found = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (ifc.done || ifc.busy) found = 1;
    end
    chk("mid_rst_no_done", found, 1'b0);
    chk("mid_rst_q_kept", lq, q_hold);

    // Stuck-at-0 latch, write 1: readback flags it; without readback, one cycle sooner.
    stuck = 1;
    ifc.req0 = 1; ifc.data0 = 1;
    tick();
    chk("stuck_gnt0", ifc.gnt0, 1'b1);
    ifc.req0 = 0;
    lat = 0; found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      lat = lat + 1;
      if (ifc.done) found = 1;
    end
    chk("stuck_done_seen", found, 1'b1);
    chk("stuck_done_lat", lat, DONE_LAT);
    chk("stuck_err", ifc.err, STUCK_ERR);
    tick();
    chk("stuck_err_clear", {ifc.done, ifc.err}, 2'b00);
    stuck = 0;

    // Gate width on PULSE_CYCLES = 1 and 15 instances.
    c1 = 0; c15 = 0; dn1 = 0; dn15 = 0;
    ifc1.req0 = 1; ifc1.data0 = 1; ifc15.req0 = 1; ifc15.data0 = 0;
    tick();
    chk("p1_gnt", ifc1.gnt0, 1'b1);
    chk("p15_gnt", ifc15.gnt0, 1'b1);
    ifc1.req0 = 0; ifc15.req0 = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      c1 = c1 + int'(ifc1.latch_C);
      c15 = c15 + int'(ifc15.latch_C);
      dn1 = dn1 + int'(ifc1.done);
      dn15 = dn15 + int'(ifc15.done);
    end
    chk("p1_gate_cycles", c1, 1);
    chk("p15_gate_cycles", c15, 15);
    chk("p1_done_count", dn1, 1);
    chk("p15_done_count", dn15, 1);

    chk("sr_never_both_low", sr_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
